// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer sharing the address bus with one DMA requester
module fetch_sequencer #(
  parameter int DMA_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  input  logic [1:0] opc_len,
  input  logic       dma_req,
  output logic       pc_ab,
  output logic       pc_inc,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic       op0_ld,
  output logic       op1_ld,
  output logic       done,
  output logic       ill,
  output logic       dma_gnt,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, OPC, DEC, OPR1, OPR2, DONE, DMA} state_t;

  state_t     state, nxt, ret, nxt_ret, dec_next;
  logic [7:0] dma_cnt;
  logic       holdoff;
  logic [1:0] rem;
  logic       ill_q, ill_nxt;
  logic       grant_ok, dma_last, bus_nxt;

  always_comb begin
    // The operand byte just read in OPR1 satisfies any pending holdoff.
    grant_ok = dma_req & (~holdoff | (state == OPR1));
    dma_last = (dma_cnt == 8'(DMA_MAX - 1));
    dec_next = (opc_len == 2'd0) ? DONE : OPR1;
    ill_nxt  = (state == DEC) ? (opc_len == 2'd3) : ill_q;
    nxt      = state;
    nxt_ret  = ret;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          nxt     = DMA;
          nxt_ret = IDLE;
        end else if (fetch_req) begin
          nxt = OPC;
        end
      end
      OPC: nxt = DEC;
      DEC: begin
        if (grant_ok) begin
          nxt     = DMA;
          nxt_ret = dec_next;
        end else begin
          nxt = dec_next;
        end
      end
      OPR1: begin
        if (rem != 2'd2) begin
          nxt = DONE;
        end else if (grant_ok) begin
          nxt     = DMA;
          nxt_ret = OPR2;
        end else begin
          nxt = OPR2;
        end
      end
      OPR2: nxt = DONE;
      DONE: nxt = IDLE;
      DMA:  if (!dma_req || dma_last) nxt = ret;
      default: nxt = IDLE;
    endcase
    bus_nxt = (nxt == OPC) || (nxt == OPR1) || (nxt == OPR2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ret     <= IDLE;
      dma_cnt <= 8'd0;
      holdoff <= 1'b0;
      rem     <= 2'd0;
      ill_q   <= 1'b0;
      pc_ab   <= 1'b0;
      pc_inc  <= 1'b0;
      mem_rd  <= 1'b0;
      ir_ld   <= 1'b0;
      op0_ld  <= 1'b0;
      op1_ld  <= 1'b0;
      done    <= 1'b0;
      ill     <= 1'b0;
      dma_gnt <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt;
      ret     <= nxt_ret;
      dma_cnt <= (state == DMA && nxt == DMA) ? dma_cnt + 8'd1 : 8'd0;
      if (state == DEC) begin
        rem   <= (opc_len == 2'd0) ? 2'd0 : (opc_len == 2'd1) ? 2'd1 : 2'd2;
        ill_q <= (opc_len == 2'd3);
      end
      // Forced release blocks an immediate regrant until the fetch makes progress.
      if (state == DMA && nxt != DMA)
        holdoff <= dma_req & dma_last;
      else if (state == OPC || state == OPR1 || state == OPR2 || (state == IDLE && !fetch_req))
        holdoff <= 1'b0;
      pc_ab   <= bus_nxt;
      pc_inc  <= bus_nxt;
      mem_rd  <= bus_nxt;
      ir_ld   <= (nxt == OPC);
      op0_ld  <= (nxt == OPR1);
      op1_ld  <= (nxt == OPR2);
      done    <= (nxt == DONE);
      ill     <= (nxt == DONE) & ill_nxt;
      dma_gnt <= (nxt == DMA);
      busy    <= (nxt != IDLE);
    end
  end

endmodule
